// File: rtl/taxi_ctrl_fsm_pkg.sv
// taxi_pkg: shared state encoding, state width and default divider values for the taxi trip controller
package taxi_pkg;
   localparam int STATE_W = 2;
   typedef enum logic [STATE_W-1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_PARK = 2'd2,
      ST_END  = 2'd3
   } state_t;
   localparam int TICK_DIV_DEF   = 5000000;
   localparam int PARK_DIV_DEF   = 10;
   localparam int DEB_CYCLES_DEF = 250000;
endpackage

// File: rtl/taxi_ctrl_fsm_if.sv
// taxi_ctrl_fsm_if: driver controls in, trip state and tick enables out
//   restart_btn/endcar_btn/park_sw : raw asynchronous controls
//   state                          : IDLE=0 RUN=1 PARK=2 END=3
//   dist_tick/park_tick/trip_clear : one-cycle pulses to the accumulator
//   trip_end                       : level, high while state==END
interface taxi_ctrl_fsm_if;
   logic                         restart_btn;
   logic                         endcar_btn;
   logic                         park_sw;
   logic [taxi_pkg::STATE_W-1:0] state;
   logic                         dist_tick;
   logic                         park_tick;
   logic                         trip_clear;
   logic                         trip_end;
   modport master (output restart_btn, endcar_btn, park_sw,
                   input  state, dist_tick, park_tick, trip_clear, trip_end);
   modport slave  (input  restart_btn, endcar_btn, park_sw,
                   output state, dist_tick, park_tick, trip_clear, trip_end);
endinterface

// File: rtl/taxi_ctrl_fsm_debounce.sv
// taxi_debounce: two-flop synchroniser plus optional debouncer (TAXI_DEBOUNCE_EN)
//   clk, rst : clock, synchronous active-high reset
//   din      : raw asynchronous input
//   dout     : conditioned level
module taxi_debounce #(
   parameter int DEB_CYCLES = 250000
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);
   logic [1:0] sync;
   if (DEB_CYCLES < 1) begin : g_bad_deb
      $error("DEB_CYCLES must be at least 1");
   end
   always_ff @(posedge clk)
      sync <= rst ? 2'b00 : {sync[0], din};
`ifdef TAXI_DEBOUNCE_EN
   localparam int CW = $clog2(DEB_CYCLES + 1);
   logic [CW-1:0] cnt;
   // cnt counts consecutive samples that disagree with dout; any agreeing sample restarts it
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         dout <= 1'b0;
      end else if (sync[1] == dout) begin
         cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
         cnt  <= '0;
         dout <= sync[1];
      end else begin
         cnt <= cnt + 1'b1;
      end
   end
`else
   assign dout = sync[1];
`endif
endmodule

// File: rtl/taxi_ctrl_fsm.sv
// taxi_ctrl_fsm: trip state machine, prescaler and tick-enable generation for the taximeter accumulator
//   clk, rst : clock, synchronous active-high reset
//   bus      : taxi_ctrl_fsm_if.slave (buttons in; state, ticks, trip_clear, trip_end out)
//   Define TAXI_DEBOUNCE_EN to insert a DEB_CYCLES debouncer after each synchroniser.
module taxi_ctrl_fsm
   import taxi_pkg::*;
#(
   parameter int TICK_DIV   = TICK_DIV_DEF,
   parameter int PARK_DIV   = PARK_DIV_DEF,
   parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
   input logic            clk,
   input logic            rst,
   taxi_ctrl_fsm_if.slave bus
);
   localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
   localparam int PW = PARK_DIV > 1 ? $clog2(PARK_DIV) : 1;
   logic          restart_c, endcar_c, park_c;
   logic          restart_q, endcar_q;
   logic          restart_e, endcar_e;
   logic [TW-1:0] presc;
   logic [PW-1:0] pcnt;
   logic          base_tick, park_adv, park_wrap;
   logic          dist_r, park_r, clear_r, end_r;
   state_t        st, st_nx;
   taxi_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_restart (.clk(clk), .rst(rst), .din(bus.restart_btn), .dout(restart_c));
   taxi_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_endcar  (.clk(clk), .rst(rst), .din(bus.endcar_btn),  .dout(endcar_c));
   taxi_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_park    (.clk(clk), .rst(rst), .din(bus.park_sw),     .dout(park_c));
   always_comb begin
      restart_e = restart_c & ~restart_q;
      endcar_e  = endcar_c & ~endcar_q;
      base_tick = presc == TW'(TICK_DIV - 1);
      park_adv  = base_tick && st == ST_PARK;
      park_wrap = park_adv && pcnt == PW'(PARK_DIV - 1);
      st_nx     = restart_e                                   ? ST_RUN  :
                  (endcar_e && (st == ST_RUN || st == ST_PARK)) ? ST_END  :
                  (st == ST_RUN && park_c)                    ? ST_PARK :
                  (st == ST_PARK && !park_c)                  ? ST_RUN  : st;
   end
   // restart_e is the cycle trip_clear is registered, so the prescaler and park
   // counter restart together with the new trip; ticks use the pre-transition state
   always_ff @(posedge clk) begin
      if (rst) begin
         st        <= ST_IDLE;
         restart_q <= 1'b0;
         endcar_q  <= 1'b0;
         presc     <= '0;
         pcnt      <= '0;
         dist_r    <= 1'b0;
         park_r    <= 1'b0;
         clear_r   <= 1'b0;
         end_r     <= 1'b0;
      end else begin
         st        <= st_nx;
         restart_q <= restart_c;
         endcar_q  <= endcar_c;
         presc     <= (restart_e || base_tick) ? '0 : presc + 1'b1;
         pcnt      <= (restart_e || park_wrap) ? '0 : park_adv ? pcnt + 1'b1 : pcnt;
         dist_r    <= base_tick && st == ST_RUN;
         park_r    <= park_wrap;
         clear_r   <= restart_e;
         end_r     <= st_nx == ST_END;
      end
   end
   assign bus.state      = st;
   assign bus.dist_tick  = dist_r;
   assign bus.park_tick  = park_r;
   assign bus.trip_clear = clear_r;
   assign bus.trip_end   = end_r;
endmodule

// File: tb/tb_taxi_ctrl_fsm.sv
// tb_taxi_ctrl_fsm: directed bench for taxi_ctrl_fsm with TICK_DIV=10, PARK_DIV=3, DEB_CYCLES=4
module tb_taxi_ctrl_fsm;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   compared = 0;
   int   mismatched = 0;
   int   nd, np, nc;
   taxi_ctrl_fsm_if bus();
   taxi_ctrl_fsm #(.TICK_DIV(10), .PARK_DIV(3), .DEB_CYCLES(4)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask
   // advance n cycles, sampling 1 time unit after each edge and counting pulses
   task automatic step(input int n);
      nd = 0;
      np = 0;
      nc = 0;
      repeat (n) begin
         @(posedge clk);
         #1;
         nd += int'(bus.dist_tick);
         np += int'(bus.park_tick);
         nc += int'(bus.trip_clear);
      end
   endtask
   initial begin
      bus.restart_btn = 1'b0;
      bus.endcar_btn  = 1'b0;
      bus.park_sw     = 1'b0;
      step(2);
      chk("rst_state", bus.state, 0);
      chk("rst_dist", bus.dist_tick, 0);
      chk("rst_park", bus.park_tick, 0);
      chk("rst_clear", bus.trip_clear, 0);
      chk("rst_end", bus.trip_end, 0);
      rst = 1'b0;
      step(2);
`ifdef TAXI_DEBOUNCE_EN
      bus.restart_btn = 1'b1;
      step(3);
      bus.restart_btn = 1'b0;
      step(12);
      chk("glitch_state", bus.state, 0);
      chk("glitch_clear", nc, 0);
      bus.restart_btn = 1'b1;
      step(6);
      bus.restart_btn = 1'b0;
      chk("deb_lat6_state", bus.state, 0);
      step(1);
      chk("deb_lat7_state", bus.state, 1);
      chk("deb_lat7_clear", bus.trip_clear, 1);
      step(3);
      bus.endcar_btn = 1'b1;
      step(6);
      bus.endcar_btn = 1'b0;
      chk("deb_end6_state", bus.state, 1);
      step(1);
      chk("deb_end7_state", bus.state, 3);
      chk("deb_end7_tripend", bus.trip_end, 1);
`else
      bus.endcar_btn = 1'b1;
      step(1);
      bus.endcar_btn = 1'b0;
      step(4);
      chk("endcar_idle_ignored", bus.state, 0);
      bus.restart_btn = 1'b1;
      step(1);
      bus.restart_btn = 1'b0;
      step(1);
      chk("restart_lat2_state", bus.state, 0);
      chk("restart_lat2_clear", bus.trip_clear, 0);
      step(1);
      chk("restart_lat3_state", bus.state, 1);
      chk("restart_lat3_clear", bus.trip_clear, 1);
      step(1);
      chk("clear_width", bus.trip_clear, 0);
      step(8);
      chk("no_early_dist", nd, 0);
      step(1);
      chk("first_dist_10", bus.dist_tick, 1);
      step(9);
      chk("dist_gap", nd, 0);
      step(1);
      chk("second_dist_20", bus.dist_tick, 1);
      bus.park_sw = 1'b1;
      step(2);
      chk("park_lat2", bus.state, 1);
      step(1);
      chk("park_lat3", bus.state, 2);
      step(26);
      chk("park_no_dist_a", nd, 0);
      chk("park_no_ptick_a", np, 0);
      step(1);
      chk("park_tick_3rd", bus.park_tick, 1);
      step(35);
      chk("park_no_dist_b", nd, 0);
      chk("park_ticks_b", np, 1);
      bus.park_sw = 1'b0;
      step(2);
      chk("unpark_lat2", bus.state, 2);
      step(1);
      chk("unpark_lat3", bus.state, 1);
      step(2);
      chk("run_dist_resume", bus.dist_tick, 1);
      bus.park_sw = 1'b1;
      step(3);
      chk("park2_state", bus.state, 2);
      step(17);
      chk("park2_no_ptick", np, 0);
      bus.park_sw = 1'b0;
      step(3);
      chk("run2_state", bus.state, 1);
      chk("run2_no_ptick", np, 0);
      step(7);
      chk("run2_dist", bus.dist_tick, 1);
      bus.park_sw = 1'b1;
      step(3);
      chk("park3_state", bus.state, 2);
      step(6);
      chk("park3_wait", np, 0);
      step(1);
      chk("park_held_wrap", bus.park_tick, 1);
      bus.endcar_btn = 1'b1;
      step(1);
      bus.endcar_btn = 1'b0;
      step(1);
      chk("endcar_lat2", bus.state, 2);
      step(1);
      chk("endcar_lat3", bus.state, 3);
      chk("trip_end_high", bus.trip_end, 1);
      step(30);
      chk("end_no_dist", nd, 0);
      chk("end_no_ptick", np, 0);
      chk("end_hold", bus.state, 3);
      bus.endcar_btn = 1'b1;
      step(1);
      bus.endcar_btn = 1'b0;
      step(5);
      chk("endcar_again", bus.state, 3);
      bus.park_sw = 1'b0;
      step(5);
      chk("end_park_ignored", bus.state, 3);
      bus.restart_btn = 1'b1;
      step(1);
      bus.restart_btn = 1'b0;
      step(2);
      chk("restart_from_end", bus.state, 1);
      chk("restart_from_end_clear", bus.trip_clear, 1);
      chk("restart_from_end_tripend", bus.trip_end, 0);
      step(5);
      bus.restart_btn = 1'b1;
      bus.endcar_btn  = 1'b1;
      step(1);
      bus.restart_btn = 1'b0;
      bus.endcar_btn  = 1'b0;
      step(2);
      chk("both_state", bus.state, 1);
      chk("both_clear", bus.trip_clear, 1);
      step(10);
      chk("both_clear_once", nc, 0);
      chk("both_still_run", bus.state, 1);
      rst = 1'b1;
      step(1);
      chk("abort_state", bus.state, 0);
      chk("abort_clear", bus.trip_clear, 0);
      rst = 1'b0;
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/taxi_ctrl_fsm.md
# taxi_ctrl_fsm

Trip-control front end of the taximeter, directly upstream of the fare/distance accumulator. Synchronises and debounces the driver controls (restart, end-of-trip, park), runs the trip state machine, and generates the tick enables the accumulator consumes. These enables are the 0.1 km distance tick, the waiting-time tick and the trip-clear pulse. The accumulator then needs no prescaler or button logic of its own.

## Interface
Parameters:
- TICK_DIV, 5000000: clk cycles per base tick; one base tick is one 0.1 km distance step.
- PARK_DIV, 10: base ticks of parking per waiting-fee tick.
- DEB_CYCLES, 250000: consecutive stable samples required to accept a button level. Used only with debounce compiled in.

Ports:
- clk  in  1  system clock, single clock domain
- rst  in  1  synchronous, active-high reset
- restart_btn  in  1  raw asynchronous button: start or restart a trip
- endcar_btn  in  1  raw asynchronous button: end the trip
- park_sw  in  1  raw asynchronous level switch: vehicle waiting
- state  out  2  current state: IDLE=0, RUN=1, PARK=2, END=3
- dist_tick  out  1  one-cycle pulse; advance distance by 0.1 km
- park_tick  out  1  one-cycle pulse; add one waiting-fee unit
- trip_clear  out  1  one-cycle pulse; zero the per-trip registers
- trip_end  out  1  level; high while state==END, so the accumulator latches the trip total

## Operation
- Input conditioning, per input: two-flop synchroniser, optional debouncer, then a registered copy for edge detection.
  - restart and endcar act on the rising edge of the conditioned signal.
  - park acts on the level of the conditioned signal.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - base_tick is an internal pulse asserted when the count equals TICK_DIV-1.
  - Cleared to 0 on rst and on trip_clear.
- State machine transitions, highest priority first:
  - rst → IDLE.
  - restart edge, in any state → RUN; trip_clear is pulsed on the same clock edge.
  - endcar edge in RUN or PARK → END. endcar in IDLE or END is ignored.
  - RUN with park high → PARK.
  - PARK with park low → RUN.
  - IDLE and END hold otherwise. Park is ignored in IDLE and END.
- dist_tick = base_tick while state==RUN.
- Park counter:
  - Advances on base_tick while state==PARK and counts 0..PARK_DIV-1.
  - park_tick is asserted on the base_tick where the counter wraps from PARK_DIV-1 to 0.
  - Holds its value while in RUN, so accumulated waiting time carries across park episodes.
  - Cleared on rst and on trip_clear.
- Simultaneous events:
  - restart and endcar edges in the same cycle: restart wins.
  - endcar edge and park change in the same cycle: endcar wins.
  - base_tick in the cycle of a transition: evaluated against the state before the transition, so at most one tick is issued.

## Timing
- Reset values: state=IDLE, dist_tick=0, park_tick=0, trip_clear=0, trip_end=0. All counters and synchroniser flops are 0.
- All outputs are registered, with no combinational input-to-output path.
- Button-to-state latency:
  - Without debounce: 3 cycles (2 sync + 1 edge/FSM).
  - With debounce: 3 + DEB_CYCLES cycles.
- trip_clear is exactly 1 cycle wide. It coincides with the first cycle of state==RUN after a restart.
- First dist_tick after trip_clear arrives exactly TICK_DIV cycles later.
- Tick pulses are 1 cycle wide and at least TICK_DIV cycles apart.
- An rst mid-trip aborts immediately. trip_clear is not pulsed; downstream clears on its own reset.

## Configuration
- TAXI_DEBOUNCE_EN defined:
  - A debouncer sits after each synchroniser.
  - The output level changes only after DEB_CYCLES consecutive identical samples.
  - The stability counter restarts on any sample mismatch.
- TAXI_DEBOUNCE_EN undefined:
  - The synchroniser output feeds edge detection directly.
  - DEB_CYCLES is unused.
  - For simulation and for boards with hardware-debounced switches.

## Structure
- Package taxi_pkg holds:
  - state encoding constants ST_IDLE, ST_RUN, ST_PARK, ST_END;
  - default TICK_DIV and PARK_DIV values;
  - the state vector width.
- Sub-module taxi_debounce, instantiated three times. It contains the synchroniser plus the debouncer and is parameterised by DEB_CYCLES. Its debouncer section is guarded by TAXI_DEBOUNCE_EN.
- Prescaler, park counter and FSM stay in this module.

## Test plan
Bench parameters: TICK_DIV=10, PARK_DIV=3, DEB_CYCLES=4. Debounce is off unless stated.
- Reset, then restart_btn pulse: state=RUN 3 cycles after the press, with one trip_clear pulse on the same edge. The first dist_tick arrives 10 cycles after trip_clear, then one every 10 cycles.
- In RUN, hold park_sw for 65 cycles: state=PARK. dist_tick stops. park_tick fires on every 3rd base tick.
- Release park, then park again 1 base tick before the prior wrap point: the park counter resumes from its held value, and park_tick fires after 1 further base tick.
- endcar_btn in PARK: state=END, trip_end=1, and no further ticks. A second endcar has no effect.
- restart_btn and endcar_btn pressed in the same cycle during RUN: state stays RUN, and trip_clear pulses once.
- With TAXI_DEBOUNCE_EN defined:
  - a 3-cycle restart glitch produces no state change;
  - a 6-cycle press produces RUN 7 cycles after the press (3 + DEB_CYCLES).
